// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the memory-port initiator and its transaction FIFO.
package mem_port_pkg;

  // Widest address the transaction record can carry; ADDR_WIDTH must not exceed it.
  localparam int unsigned TXN_ADDR_WIDTH = 64;

  // One granted transaction awaiting its completion.
  typedef struct packed {
    logic [TXN_ADDR_WIDTH-1:0] addr;
    logic                      we;
  } txn_t;

  // Bits needed to count 0..max_out outstanding transactions.
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/mem_port_txn_fifo.sv
// In-order FIFO of granted transactions; simultaneous push and pop allowed.
module mem_port_txn_fifo
  import mem_port_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = cnt_width(DEPTH),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  txn_t             push_data_i,
  input  logic             pop_i,
  output txn_t             head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  txn_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage array: written on push, read combinationally at the read pointer.
  // NOTE: the data array has no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers and occupancy, wrapping modulo DEPTH.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      count_q <= count_q + CNT_W'(1);
      else if (pop_i && !push_i) count_q <= count_q - CNT_W'(1);
    end
  end

  // The parent never overfills or over-drains this FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_i && full_o));
      assert (!(pop_i && empty_o));
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mem_port_initiator.sv
// Initiator side of the req/gnt/rvalid RAM port with in-order completion tracking.
module mem_port_initiator
  import mem_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic                  cmd_we_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  output logic [ADDR_WIDTH-1:0] rsp_addr_o,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  port_req_o,
  input  logic                  port_gnt_i,
  input  logic                  port_rvalid_i,
  output logic [ADDR_WIDTH-1:0] port_addr_o,
  output logic                  port_we_o,
  output logic [DATA_WIDTH-1:0] port_wdata_o,
  input  logic [DATA_WIDTH-1:0] port_rdata_i,
  output logic                  err_o
);

  localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);

  // Request stage
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  // Response and error
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic                  rsp_we_q, rsp_we_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  err_q, err_d;

  logic             grant, accept, pop, cmd_ready;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W:0]   occ_after;
  txn_t             push_txn, head_txn;

  // A completion is only real while something is outstanding; a stray rvalid
  // must not free a slot, or MAX_OUTSTANDING=1 could overfill the FIFO.
  assign grant     = req_q && port_gnt_i;
  assign pop       = port_rvalid_i && !fifo_empty;
  assign occ_after = {1'b0, outstanding} + (CNT_W+1)'(req_q) - (CNT_W+1)'(pop);
  assign cmd_ready = (!req_q || port_gnt_i) &&
                     (occ_after < (CNT_W+1)'(MAX_OUTSTANDING));
  assign accept    = cmd_valid_i && cmd_ready;

  assign push_txn.addr = TXN_ADDR_WIDTH'(addr_q);
  assign push_txn.we   = we_q;

  mem_port_txn_fifo #(.DEPTH(MAX_OUTSTANDING)) u_txn_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (grant),
    .push_data_i (push_txn),
    .pop_i       (pop),
    .head_o      (head_txn),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (outstanding)
  );

  // Next state: stage load/hold/clear, completion capture, sticky error.
  // NOTE: every _d gets a default first so no path infers a latch.
  always_comb begin
    req_d       = req_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rsp_valid_d = pop;
    rsp_addr_d  = rsp_addr_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = err_q | (port_rvalid_i && fifo_empty);
    if (accept) begin
      req_d   = 1'b1;
      addr_d  = cmd_addr_i;
      we_d    = cmd_we_i;
      wdata_d = cmd_wdata_i;
    end else if (grant) begin
      req_d = 1'b0;
    end
    if (pop) begin
      rsp_addr_d  = ADDR_WIDTH'(head_txn.addr);
      rsp_we_d    = head_txn.we;
      rsp_rdata_d = port_rdata_i;
    end
  end

  // State registers; reset drops any pending request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      req_q       <= req_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready_o  = cmd_ready;
  assign port_req_o   = req_q;
  assign port_addr_o  = addr_q;
  assign port_we_o    = we_q;
  assign port_wdata_o = wdata_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_addr_o   = rsp_addr_q;
  assign rsp_we_o     = rsp_we_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign err_o        = err_q;

endmodule

// File: doc/mem_port_initiator.md
# mem_port_initiator

Initiator end of the memory port used by the single- and dual-port RAMs (req/gnt/rvalid handshake). It takes read and write commands from a client through a valid/ready interface and drives them onto the RAM port. It tracks up to MAX_OUTSTANDING granted transactions and returns every completion in order, tagged with its address and direction. It sits between the core-side test/control logic and the RAM's `port_*` pins, including the ones that reach `mem_flag` and `mem_result`.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of command and port
- DATA_WIDTH, 32, data width of command, port and response
- MAX_OUTSTANDING, 2, maximum granted-but-not-completed transactions (≥1)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  client command valid
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_addr_i  in  ADDR_WIDTH  command address
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_wdata_i  in  DATA_WIDTH  write data
- rsp_valid_o  out  1  one-cycle completion pulse; client cannot stall it
- rsp_addr_o  out  ADDR_WIDTH  address of the completed transaction
- rsp_we_o  out  1  direction of the completed transaction
- rsp_rdata_o  out  DATA_WIDTH  read data (write completions also carry port_rdata_i)
- port_req_o  out  1  request to RAM
- port_gnt_i  in  1  RAM grant
- port_rvalid_i  in  1  RAM completion, in order
- port_addr_o  out  ADDR_WIDTH  request address
- port_we_o  out  1  request direction
- port_wdata_o  out  DATA_WIDTH  request write data
- port_rdata_i  in  DATA_WIDTH  RAM read data, valid with port_rvalid_i
- err_o  out  1  sticky protocol error

## Operation
- Request stage: registered flag req_q plus registered addr, we and wdata. port_req_o = req_q. port_addr_o, port_we_o and port_wdata_o come from the stage registers.
- Accept: cmd_ready_o = (!req_q || port_gnt_i) && (occ − port_rvalid_i < MAX_OUTSTANDING).
  - occ = outstanding count + req_q.
  - The path from gnt/rvalid to ready is combinational by design.
  - On accept, the stage loads the command and req_q becomes 1 on the next edge.
- Hold: while req_q && !port_gnt_i, the request payload stays stable and req_q stays 1. A request is never withdrawn.
- Grant: on req_q && port_gnt_i:
  - push {addr, we} into the transaction FIFO and increment outstanding;
  - if no command is accepted in the same cycle, req_q clears.
- Back-to-back: grant and accept in the same cycle reloads the stage, so port_req_o stays high with no bubble.
- Completion: on port_rvalid_i with outstanding > 0:
  - pop the FIFO and decrement outstanding;
  - register rsp_valid_o=1, rsp_addr_o/rsp_we_o from the FIFO head and rsp_rdata_o=port_rdata_i.
- Simultaneous grant and rvalid: push and pop in the same cycle, outstanding unchanged.
- Error: port_rvalid_i with outstanding == 0 sets err_o and is otherwise ignored (no rsp, no pop). port_gnt_i with !req_q is ignored.
- err_o clears only on rst.

## Timing
- Reset values:
  - port_req_o=0, port_addr_o=0, port_we_o=0, port_wdata_o=0;
  - rsp_valid_o=0, rsp_addr_o=0, rsp_we_o=0, rsp_rdata_o=0;
  - err_o=0, outstanding=0, FIFO empty;
  - cmd_ready_o=1 (combinational, out of reset).
- Accept → port_req_o: 1 cycle.
- Zero-wait grant: port_gnt_i may be asserted in the same cycle that port_req_o rises.
- rvalid → rsp_valid_o: 1 cycle. rsp_valid_o is high for exactly one cycle per completion.
- Sustained throughput with same-cycle gnt and rvalid 1 cycle after gnt: 1 transaction/cycle, provided MAX_OUTSTANDING ≥ 2.
- Full: with occ == MAX_OUTSTANDING and no rvalid, cmd_ready_o=0. An rvalid in that cycle re-opens ready in the same cycle.
- Reset mid-operation: all state is cleared asynchronously and the pending request is dropped. A late rvalid after reset sets err_o.

## Structure
- Package mem_port_pkg holds:
  - typedef txn_t {logic [ADDR_WIDTH-1:0] addr; logic we;};
  - the outstanding-counter width function $clog2(MAX_OUTSTANDING+1).
- One sub-module, mem_port_txn_fifo:
  - synchronous FIFO of txn_t, depth MAX_OUTSTANDING;
  - push, pop, full and empty signals, simultaneous push/pop allowed;
  - pointers wrap modulo depth;
  - same clk and rst as the parent.
- Pushing when full, or popping when empty, is unreachable by construction and is asserted in the FIFO.

## Test plan
- Single read, gnt in same cycle, rvalid 1 cycle later with rdata=0xDEADBEEF:
  - cmd addr=0x10 is accepted;
  - port_req_o rises next cycle;
  - rsp_valid_o, rsp_addr_o=0x10, rsp_we_o=0 and rsp_rdata_o=0xDEADBEEF appear 1 cycle after rvalid.
- Write addr=0x20 wdata=0x5A5A5A5A with gnt held low for 3 cycles:
  - port_req_o, port_addr_o and port_wdata_o stay stable for those 3 cycles;
  - cmd_ready_o=0 throughout;
  - completion has rsp_we_o=1.
- Four back-to-back reads 0x0,0x4,0x8,0xC with gnt always 1 and rvalid 1 cycle after each gnt:
  - port_req_o stays high for 4 consecutive cycles;
  - rsp_addr_o sequence is 0x0,0x4,0x8,0xC with no gaps.
- MAX_OUTSTANDING=2 with rvalid withheld:
  - after two grants cmd_ready_o=0;
  - the first rvalid raises cmd_ready_o in that same cycle.
- Spurious port_rvalid_i while idle:
  - err_o=1 next cycle and remains 1;
  - rsp_valid_o stays 0;
  - rst returns err_o to 0.
- Assert rst while one transaction is outstanding and one is pending:
  - all outputs return to their reset values immediately;
  - a subsequent rvalid sets err_o.
